// File: rtl/alu_uart_arbiter.sv
// alu_uart_arbiter: shares one ALU+UART core between the manual panel (id 0)
// and the CPU decode/writeback path (id 1). Each winner's operands are
// latched at the grant. The block issues exactly one alu_ena per transaction
// and follows the UART transfer through uart_busy. The result is returned,
// tagged with its owner, once the transfer is done.
// Optional build macro: ARB_ROUND_ROBIN_EN makes contested grants alternate.
// Without it, the CPU always wins a contested grant.
module alu_uart_arbiter #(
  parameter int DATA_W       = 8,
  parameter int RES_W        = 16,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              m_req,
  input  logic [DATA_W-1:0] m_a,
  input  logic [DATA_W-1:0] m_b,
  input  logic [2:0]        m_op,
  output logic              m_ack,
  input  logic              c_req,
  input  logic [DATA_W-1:0] c_a,
  input  logic [DATA_W-1:0] c_b,
  input  logic [2:0]        c_op,
  output logic              c_ack,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_ena,
  input  logic [RES_W-1:0]  alu_result,
  input  logic              uart_busy,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [RES_W-1:0]  rsp_data,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_START = 3'd2,
    WAIT_END   = 3'd3,
    RESP       = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(BUSY_TIMEOUT);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [RES_W-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_id_q, rsp_id_d;
  logic              timeout_err_q, timeout_err_d;
  logic              win_cpu;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;
  // Contested requests go to the id that did not win last time
  assign win_cpu = (m_req && c_req) ? ~last_grant_q : c_req;
`else
  // Contested requests always go to the CPU
  assign win_cpu = c_req;
`endif

  // Next-state and datapath update; with ena low everything holds
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    rsp_data_d    = rsp_data_q;
    rsp_id_d      = rsp_id_q;
    timeout_err_d = timeout_err_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d  = last_grant_q;
`endif
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (!uart_busy && (m_req || c_req)) begin
            owner_d  = win_cpu;
            alu_a_d  = win_cpu ? c_a : m_a;
            alu_b_d  = win_cpu ? c_b : m_b;
            alu_op_d = win_cpu ? c_op : m_op;
            state_d  = ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_d = win_cpu;
`endif
          end
        end
        ISSUE: begin
          cnt_d   = '0;
          state_d = WAIT_START;
        end
        WAIT_START: begin
          if (uart_busy) begin
            state_d = WAIT_END;
          end else begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == TIMEOUT_LIMIT) begin
              // Abandon the wait. The response is captured on entry to RESP,
              // so rsp_data is valid in the same cycle as rsp_valid.
              timeout_err_d = 1'b1;
              rsp_data_d    = alu_result;
              rsp_id_d      = owner_q;
              state_d       = RESP;
            end
          end
        end
        WAIT_END: begin
          if (!uart_busy) begin
            rsp_data_d = alu_result;
            rsp_id_d   = owner_q;
            state_d    = RESP;
          end
        end
        RESP: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      owner_q       <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      rsp_data_q    <= '0;
      rsp_id_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      rsp_data_q    <= rsp_data_d;
      rsp_id_q      <= rsp_id_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Round-robin history; starts at CPU so manual wins the first contest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Pulses come straight from registered state, gated by ena. A frozen
  // pulse therefore reappears in the first cycle ena is back.
  assign alu_ena     = ena && (state_q == ISSUE);
  assign m_ack       = alu_ena && !owner_q;
  assign c_ack       = alu_ena && owner_q;
  assign rsp_valid   = ena && (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_id      = rsp_id_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/alu_uart_arbiter.md
Name: alu_uart_arbiter

Overview:
- Shares the single ALU+UART core (FSM) between two requesters: the manual panel path (id 0) and the CPU decode/writeback path (id 1).
- Accepts requests over a req/ack handshake and latches each winner's operands.
- Issues exactly one alu_ena pulse per transaction, then tracks the UART transfer via uart_busy. It returns the 16-bit result, tagged with the owner id, once the transfer completes.
- Sits between SWITCH/DECODER outputs and the FSM in tt_um_Jsilicon and replaces the mode-based static mux.

Parameters:
- DATA_W, 8, operand width
- RES_W, 16, ALU result width
- BUSY_TIMEOUT, 15, cycles to wait for uart_busy to rise after issue before abandoning the wait (1..255)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global enable; low freezes the block
- m_req  in  1  manual request, held until m_ack
- m_a, m_b  in  DATA_W  manual operands
- m_op  in  3  manual opcode
- m_ack  out  1  one-cycle grant pulse to manual
- c_req  in  1  CPU request, held until c_ack
- c_a, c_b  in  DATA_W  CPU operands
- c_op  in  3  CPU opcode
- c_ack  out  1  one-cycle grant pulse to CPU
- alu_a, alu_b  out  DATA_W  operands to FSM (registered)
- alu_op  out  3  opcode to FSM (registered)
- alu_ena  out  1  one-cycle issue strobe to FSM
- alu_result  in  RES_W  FSM result
- uart_busy  in  1  FSM UART busy
- rsp_valid  out  1  one-cycle result strobe
- rsp_id  out  1  owner of rsp_data (0 manual, 1 CPU)
- rsp_data  out  RES_W  captured result
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky; set on busy timeout

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0: alu_a, alu_b, alu_op, rsp_data, rsp_id, acks, alu_ena, rsp_valid, busy, timeout_err.
  - last_grant goes to 1 (CPU).
  - Timeout counter goes to 0.
  - Reset mid-transaction abandons it; no rsp_valid is produced.
- ena=0: state, counter and registers hold. alu_ena, acks and rsp_valid are forced 0. Pulses suppressed this way are emitted in the first cycle after ena returns.
- States: IDLE, ISSUE, WAIT_START, WAIT_END, RESP.
- IDLE:
  - Grants only when ena=1, uart_busy=0 and at least one req is high.
  - On the grant edge: latch the winner's a, b and op into alu_a, alu_b and alu_op; store owner; go to ISSUE.
  - The matching ack is registered, so it is high during the ISSUE cycle.
- ISSUE: alu_ena=1 for exactly this cycle; the ack pulse is high in the same cycle. Go to WAIT_START and clear the counter.
- WAIT_START:
  - uart_busy=1: go to WAIT_END.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT: set timeout_err and go to RESP.
- WAIT_END: on uart_busy=0, go to RESP.
- RESP:
  - Capture alu_result into rsp_data and owner into rsp_id.
  - rsp_valid=1 for one cycle; go to IDLE.
  - rsp_data and rsp_id hold until the next RESP.
- alu_a, alu_b and alu_op stay stable from grant until the next grant.
- Handshake:
  - A requester sees ack one cycle after being sampled. Operands are already captured at that point.
  - A req still high after ack counts as a new request; it is considered only on return to IDLE.
  - A req dropped before ack is discarded silently.
- Minimum transaction is 5 cycles (IDLE→ISSUE→WAIT_START→WAIT_END→RESP). With a 1-cycle uart_busy, back-to-back throughput is one grant per 5 cycles.
- Arbitration (default): fixed priority, CPU over manual when both requests are high.
- uart_busy already high while in IDLE: no grant until it falls.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, grant the id opposite to last_grant, then update last_grant to the winner. Because last_grant resets to 1, the manual path wins the first contested grant after reset.
- Undefined: fixed CPU priority. last_grant is not implemented.
- A single requester is always granted in either build.

Test Plan:
- Manual only, m_a=8'h03, m_b=8'h05, m_op=3'b000; FSM model returns 16'h0008 and holds uart_busy for 10 cycles → m_ack in cycle 2, alu_ena exactly once, rsp_valid with rsp_id=0, rsp_data=16'h0008, no c_ack.
- m_req and c_req both high from reset release, default build → first grant goes to CPU. Manual is granted only after CPU's rsp_valid, and its own rsp_valid follows later.
- Same stimulus with ARB_ROUND_ROBIN_EN, both requests held high for 4 transactions → grant order manual, CPU, manual, CPU.
- uart_busy held 0 after issue, BUSY_TIMEOUT=15 → rsp_valid exactly 15 cycles after WAIT_START entry and timeout_err=1. timeout_err remains 1 after the next normal transaction.
- ena dropped for 3 cycles during ISSUE → no alu_ena while ena=0; a single alu_ena in the first cycle after ena returns; transaction completes normally.
- rst_n pulsed low during WAIT_END → all outputs 0 immediately (asynchronously) and no rsp_valid. A new c_req afterwards is granted normally.
